// File: rtl/cq_np_credit_ctrl.sv
// Non-posted credit gate for the legacy CQ stream; CC completions return credit.
// Optional watchdog enabled by defining CQ_NP_TIMEOUT_EN.
module cq_np_credit_ctrl #(
  parameter int DATA_WIDTH     = 128,
  parameter int KEEP_WIDTH     = DATA_WIDTH/8,
  parameter int MAX_NP         = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_cq_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_cq_tkeep,
  input  logic                  s_axis_cq_tlast,
  input  logic [84:0]           s_axis_cq_tuser,
  input  logic                  s_axis_cq_tvalid,
  output logic [3:0]            s_axis_cq_tready,
  output logic [DATA_WIDTH-1:0] m_axis_cq_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_cq_tkeep,
  output logic                  m_axis_cq_tlast,
  output logic [84:0]           m_axis_cq_tuser,
  output logic                  m_axis_cq_tvalid,
  input  logic [3:0]            m_axis_cq_tready,
  input  logic                  cc_tvalid,
  input  logic                  cc_tready,
  input  logic                  cc_tlast,
  output logic [7:0]            np_outstanding,
  output logic                  np_stall,
  output logic                  np_timeout
);

  typedef enum logic {
    SOP = 1'b0,
    PKT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] fmt;
  logic [4:0] typ;
  logic       is_np;
  logic       full;
  logic       hold;
  logic       hs;
  logic       inc;
  logic       dec;
  logic       dec_eff;
  logic       wd_fire;

  assign fmt = s_axis_cq_tdata[31:29];
  assign typ = s_axis_cq_tdata[28:24];

  assign is_np = ((typ == 5'b00000) & ~fmt[1])
               | (typ == 5'b00001)
               | (typ == 5'b00010);

  assign full = (cnt_q == 8'(MAX_NP));
  assign hold = (state_q == SOP) & s_axis_cq_tvalid
              & is_np & full;

  assign m_axis_cq_tdata  = s_axis_cq_tdata;
  assign m_axis_cq_tkeep  = s_axis_cq_tkeep;
  assign m_axis_cq_tlast  = s_axis_cq_tlast;
  assign m_axis_cq_tuser  = s_axis_cq_tuser;
  assign m_axis_cq_tvalid = s_axis_cq_tvalid & ~hold;
  assign s_axis_cq_tready = {4{m_axis_cq_tready[0] & ~hold}};
  assign np_stall         = hold;
  assign np_outstanding   = cnt_q;

  assign hs      = m_axis_cq_tvalid & m_axis_cq_tready[0];
  assign inc     = hs & (state_q == SOP) & is_np;
  assign dec     = cc_tvalid & cc_tready & cc_tlast;
  // A completion with nothing outstanding is stray and ignored.
  assign dec_eff = dec & (cnt_q != 8'd0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SOP: if (hs & ~s_axis_cq_tlast) state_d = PKT;
      PKT: if (hs & s_axis_cq_tlast) state_d = SOP;
      default: state_d = SOP;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      inc & ~dec_eff: cnt_d = cnt_q + 8'd1;
      dec_eff & ~inc: cnt_d = cnt_q - 8'd1;
      default: ;
    endcase
    if (wd_fire) cnt_d = 8'd0;
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q <= SOP;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CQ_NP_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        wd_run;
  logic        to_q;
  logic        unused_ok;

  assign wd_run  = (cnt_q != 8'd0) & ~dec;
  assign wd_fire = wd_run
                 & (wd_q == 16'(TIMEOUT_CYCLES - 1));
  assign wd_d    = (wd_run & ~wd_fire) ? wd_q + 16'd1
                                       : 16'd0;

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      wd_q <= 16'd0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_fire) to_q <= 1'b1;
    end
  end

  assign np_timeout = to_q;
  assign unused_ok  = ^m_axis_cq_tready[3:1];
`else
  logic unused_ok;

  assign wd_fire    = 1'b0;
  assign np_timeout = 1'b0;
  assign unused_ok  = ^{m_axis_cq_tready[3:1],
                        32'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_cq_np_credit_ctrl.sv
// Bench for cq_np_credit_ctrl: directed scenarios plus random traffic
// checked every cycle against a transaction-level credit model.
module tb_cq_np_credit_ctrl;
  localparam int DW    = 128;
  localparam int KW    = DW/8;
  localparam int MAXNP = 2;
  localparam int TO    = 16;

  logic          clk = 1'b0;
  logic          user_reset;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast;
  logic [84:0]   s_tuser;
  logic          s_tvalid;
  logic [3:0]    s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic [84:0]   m_tuser;
  logic          m_tvalid;
  logic [3:0]    m_tready;
  logic          cc_tvalid, cc_tready, cc_tlast;
  logic [7:0]    np_outstanding;
  logic          np_stall;
  logic          np_timeout;

  always #5 clk = ~clk;

  cq_np_credit_ctrl #(
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .MAX_NP(MAXNP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .user_clk(clk),
    .user_reset(user_reset),
    .s_axis_cq_tdata(s_tdata),
    .s_axis_cq_tkeep(s_tkeep),
    .s_axis_cq_tlast(s_tlast),
    .s_axis_cq_tuser(s_tuser),
    .s_axis_cq_tvalid(s_tvalid),
    .s_axis_cq_tready(s_tready),
    .m_axis_cq_tdata(m_tdata),
    .m_axis_cq_tkeep(m_tkeep),
    .m_axis_cq_tlast(m_tlast),
    .m_axis_cq_tuser(m_tuser),
    .m_axis_cq_tvalid(m_tvalid),
    .m_axis_cq_tready(m_tready),
    .cc_tvalid(cc_tvalid),
    .cc_tready(cc_tready),
    .cc_tlast(cc_tlast),
    .np_outstanding(np_outstanding),
    .np_stall(np_stall),
    .np_timeout(np_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_cnt;
  int m_age;
  bit m_inpkt;
  bit m_to;

  logic [DW-1:0] td;
  logic [7:0]    hlist [10] = '{8'h00, 8'h20, 8'h01, 8'h21, 8'h02,
                                8'h42, 8'h40, 8'h60, 8'h04, 8'h30};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit np_of(input logic [7:0] h);
    logic [2:0] f;
    logic [4:0] t;
    f = h[7:5];
    t = h[4:0];
    return (t == 5'd0 && !f[1]) || t == 5'd1 || t == 5'd2;
  endfunction

  task automatic do_reset();
    user_reset = 1'b1;
    s_tvalid   = 1'b0;
    cc_tvalid  = 1'b0;
    cc_tready  = 1'b0;
    cc_tlast   = 1'b0;
    @(posedge clk);
    #1;
    user_reset = 1'b0;
    m_cnt   = 0;
    m_age   = 0;
    m_inpkt = 1'b0;
    m_to    = 1'b0;
  endtask

  // One clock: drive, check combinational outputs, advance the model.
  task automatic cyc(input bit v, input logic [7:0] h, input bit last,
                     input bit rdy, input logic [2:0] ccv);
    bit hold, hs, inc, dec, fire;
    td = {$urandom, $urandom, $urandom, $urandom};
    td[31:24] = h;
    s_tdata   = td;
    s_tkeep   = KW'($urandom);
    s_tlast   = last;
    s_tuser   = 85'({$urandom, $urandom, $urandom});
    s_tvalid  = v;
    m_tready  = {3'($urandom), rdy};
    cc_tvalid = ccv[2];
    cc_tready = ccv[1];
    cc_tlast  = ccv[0];
    #1;
    hold = !m_inpkt && v && np_of(h) && m_cnt == MAXNP;
    check("m_tvalid", 32'(m_tvalid), 32'(v && !hold));
    check("s_tready", 32'(s_tready), 32'({4{rdy && !hold}}));
    check("np_stall", 32'(np_stall), 32'(hold));
    check("np_outstanding", 32'(np_outstanding), 32'(m_cnt));
    check("np_timeout", 32'(np_timeout), 32'(m_to));
    check("tdata_hi", m_tdata[127:96], td[127:96]);
    check("tlast", 32'(m_tlast), 32'(last));
    hs   = v && !hold && rdy;
    inc  = hs && !m_inpkt && np_of(h);
    dec  = (ccv == 3'b111);
    fire = 1'b0;
    if (hs) m_inpkt = !last;
`ifdef CQ_NP_TIMEOUT_EN
    if (m_cnt != 0 && !dec) begin
      m_age++;
      if (m_age == TO) begin
        fire  = 1'b1;
        m_age = 0;
      end
    end else begin
      m_age = 0;
    end
`endif
    m_cnt = m_cnt + int'(inc) - int'(dec && m_cnt > 0);
    if (fire) begin
      m_cnt = 0;
      m_to  = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit       v, last, rdy;
    logic [7:0] h;
    logic [2:0] ccv;
    user_reset = 1'b1;
    s_tdata    = '0;
    s_tkeep    = '0;
    s_tlast    = 1'b0;
    s_tuser    = '0;
    s_tvalid   = 1'b0;
    m_tready   = '0;
    cc_tvalid  = 1'b0;
    cc_tready  = 1'b0;
    cc_tlast   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    #1;
    check("rst_cnt", 32'(np_outstanding), 32'd0);
    check("rst_timeout", 32'(np_timeout), 32'd0);
    check("rst_stall", 32'(np_stall), 32'd0);
    check("rst_mvalid", 32'(m_tvalid), 32'd0);

    // Posted writes never throttle
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'h60, 0, 1, 3'b000);
      cyc(1, 8'h60, 1, 1, 3'b000);
    end
    check("posted_cnt", 32'(np_outstanding), 32'd0);

    // Fill credits, then stall the third read
    cyc(1, 8'h00, 1, 1, 3'b000);
    cyc(1, 8'h00, 1, 1, 3'b000);
    check("two_reads", 32'(np_outstanding), 32'd2);
    s_tvalid = 1'b1;
    s_tdata[31:24] = 8'h00;
    m_tready = 4'hF;
    #1;
    check("third_stall", 32'(np_stall), 32'd1);
    check("third_tready", 32'(s_tready), 32'h0);
    cyc(1, 8'h00, 1, 1, 3'b111);
    check("release_cnt", 32'(np_outstanding), 32'd1);
    cyc(1, 8'h00, 1, 1, 3'b000);
    check("refill_cnt", 32'(np_outstanding), 32'd2);

    // Simultaneous increment and decrement at count 1
    cyc(0, 8'h00, 1, 1, 3'b111);
    cyc(1, 8'h00, 1, 1, 3'b111);
    check("simul_cnt", 32'(np_outstanding), 32'd1);

    // Stray completion at zero
    cyc(0, 8'h00, 1, 1, 3'b111);
    cyc(0, 8'h00, 1, 1, 3'b111);
    check("stray_cnt", 32'(np_outstanding), 32'd0);

    // Reset mid-packet: next beat is a header
    cyc(1, 8'h60, 0, 1, 3'b000);
    cyc(1, 8'h60, 0, 1, 3'b000);
    do_reset();
    cyc(1, 8'h00, 1, 1, 3'b000);
    check("post_rst_hdr", 32'(np_outstanding), 32'd1);

`ifdef CQ_NP_TIMEOUT_EN
    do_reset();
    cyc(1, 8'h00, 1, 1, 3'b000);
    repeat (15) cyc(0, 8'h00, 1, 1, 3'b000);
    check("wd_early", 32'(np_timeout), 32'd0);
    cyc(0, 8'h00, 1, 1, 3'b000);
    check("wd_fire", 32'(np_timeout), 32'd1);
    check("wd_cnt", 32'(np_outstanding), 32'd0);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v    = ($urandom_range(0, 9) < 7);
      h    = hlist[$urandom_range(0, 9)];
      last = ($urandom_range(0, 2) == 0);
      rdy  = ($urandom_range(0, 4) != 0);
      ccv  = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom);
      cyc(v, h, last, rdy, ccv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cq_np_credit_ctrl.md
# cq_np_credit_ctrl

Completer-request flow controller between the CQ adapter output and the user-side request handler. Tracks outstanding non-posted requests (reads, locked reads, I/O) on the legacy-format CQ stream. Holds off a new non-posted packet at its first beat once MAX_NP are outstanding, and returns one credit per completion packet seen on the CC stream. Posted writes always pass and are never throttled.

## Interface
Parameters:
- DATA_WIDTH, 128, CQ datapath width (128/256/512).
- KEEP_WIDTH, DATA_WIDTH/8, byte-keep width.
- MAX_NP, 8, maximum outstanding non-posted requests (1..255).
- TIMEOUT_CYCLES, 65535, watchdog limit (only with CQ_NP_TIMEOUT_EN).

Ports:
- user_clk  in  1  clock. Single clock domain.
- user_reset  in  1  synchronous, active-high reset.
- s_axis_cq_tdata  in  DATA_WIDTH  adapter output data; [63:0] of the first beat is the legacy header.
- s_axis_cq_tkeep  in  KEEP_WIDTH  keep.
- s_axis_cq_tlast  in  1  last beat.
- s_axis_cq_tuser  in  85  sideband.
- s_axis_cq_tvalid  in  1  valid.
- s_axis_cq_tready  out  4  ready, all four bits identical.
- m_axis_cq_tdata/tkeep/tlast/tuser  out  as above  combinational pass-through.
- m_axis_cq_tvalid  out  1  gated valid.
- m_axis_cq_tready  in  4  user ready; only bit 0 is used.
- cc_tvalid, cc_tready, cc_tlast  in  1 each  CC stream monitor.
- np_outstanding  out  8  current outstanding count.
- np_stall  out  1  high while a first beat is held for lack of credit.
- np_timeout  out  1  sticky watchdog flag.

## Operation
- Non-posted decode on the first beat uses the header fields fmt = tdata[31:29] and type = tdata[28:24]. A beat is non-posted when:
  - type == 5'b00000 and fmt[1] == 0 (memory read), or
  - type == 5'b00001 (locked read), or
  - type == 5'b00010 (I/O read or write).
- State is a single in_pkt flag:
  - SOP: in_pkt = 0. Transitions to PKT on a handshake without tlast.
  - PKT: in_pkt = 1. Transitions to SOP on a handshake with tlast.
- Gating: hold = !in_pkt & s_axis_cq_tvalid & is_np & (np_outstanding == MAX_NP).
  - m_axis_cq_tvalid = s_axis_cq_tvalid & !hold.
  - s_axis_cq_tready = {4{m_axis_cq_tready[0] & !hold}}.
  - np_stall = hold.
- Handshake is defined as m_axis_cq_tvalid & m_axis_cq_tready[0].
- Increment: on an SOP handshake with is_np.
- Decrement: on cc_tvalid & cc_tready & cc_tlast.
- Simultaneous increment and decrement: count unchanged.
- Decrement at 0 saturates at 0 (stray completion). Increment never exceeds MAX_NP, which the gating guarantees.
- Beats in PKT are never gated. Posted packets are never gated.

## Timing
- Data, keep, last and tuser have zero latency (wires). Valid and ready are combinational from the registered count.
- np_outstanding updates on the clock edge after the handshake.
- Credit release: a completion in the same cycle as a held first beat does not release it that cycle. The beat passes on the next cycle, one cycle of added latency.
- Reset values:
  - np_outstanding = 0, in_pkt = 0, np_timeout = 0.
  - np_stall and m_axis_cq_tvalid follow the inputs; both are 0 when s_axis_cq_tvalid = 0.
- Reset mid-packet: in_pkt returns to SOP. The next beat is treated as a first beat.

## Configuration
- CQ_NP_TIMEOUT_EN defined:
  - A 16-bit watchdog increments each cycle while np_outstanding != 0 and no decrement occurs.
  - It clears on any decrement or when np_outstanding == 0.
  - On reaching TIMEOUT_CYCLES it sets np_timeout (sticky until user_reset), forces np_outstanding to 0, and clears itself.
- Undefined: no watchdog logic; np_timeout tied to 0.

## Test plan
- 3 posted writes, each 2 beats, with MAX_NP = 2 -> all pass with no stall; np_outstanding stays 0.
- 2 single-beat memory reads (fmt 000, type 00000), then a third read, MAX_NP = 2 -> the first two pass and np_outstanding = 2; the third has np_stall = 1 and s_axis_cq_tready = 4'h0.
- The stalled third read, then a CC tlast handshake in cycle N -> the read passes in cycle N+1; np_outstanding goes 2 -> 1 -> 2.
- Read SOP handshake and CC tlast in the same cycle with count 1 -> count remains 1.
- CC tlast with count 0 -> count remains 0. Reset asserted mid 3-beat write -> the next beat is decoded as a header.
- With CQ_NP_TIMEOUT_EN and TIMEOUT_CYCLES = 16, one read and no completion -> np_timeout rises 16 cycles after count leaves 0; count returns to 0.
